// File: rtl/fc_pkg.sv
// Shared types and defaults for the fully-connected layer sequencer.
// Holds the FSM state encoding and the window-width helper.
package fc_pkg;

    localparam int SIZE_D      = 16;
    localparam int LAYER_SZ_D  = 10;
    localparam int OUTPUT_SZ_D = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        SWEEP,
        DONE
    } state_t;

    // Only meaningful while addr < layer_sz, so the subtraction cannot go negative.
    function automatic int win_count_f(
        input int addr,
        input int layer_sz  = LAYER_SZ_D,
        input int output_sz = OUTPUT_SZ_D
    );
        int rem;
        rem = layer_sz - addr;
        return (rem < output_sz) ? rem : output_sz;
    endfunction

endpackage

// File: rtl/fc_layer_sequencer.sv
// Fills the neuron bank from a stream, then sweeps OUTPUT_SZ-wide windows downstream; LAYER_SZ+ceil(LAYER_SZ/OUTPUT_SZ)+2 cycles best case.
// Backpressure: in_valid low stalls the fill, win_ready low holds the current window stable.
module fc_layer_sequencer
    import fc_pkg::*;
#(
    parameter int SIZE      = SIZE_D,
    parameter int LAYER_SZ  = LAYER_SZ_D,
    parameter int OUTPUT_SZ = OUTPUT_SZ_D
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             start,
    input  logic                             in_valid,
    input  logic [SIZE-1:0]                  in_data,
    output logic                             in_ready,
    output logic [SIZE-1:0]                  load_value,
    output logic [SIZE-1:0]                  load_address,
    output logic                             load_enable,
    output logic                             win_valid,
    output logic [$clog2(OUTPUT_SZ+1)-1:0]   win_count,
    output logic                             win_last,
    input  logic                             win_ready,
    output logic                             busy,
    output logic                             done
);

    localparam int               CW        = $clog2(OUTPUT_SZ + 1);
    localparam logic [SIZE-1:0]  LAST_ADDR = SIZE'(LAYER_SZ - 1);
    localparam logic [SIZE-1:0]  ONE       = SIZE'(1);
    localparam logic [SIZE-1:0]  STEP      = SIZE'(OUTPUT_SZ);
    localparam logic [SIZE:0]    STEP_W    = (SIZE+1)'(OUTPUT_SZ);
    localparam logic [SIZE:0]    LAYER_W   = (SIZE+1)'(LAYER_SZ);

    state_t          state;
    state_t          state_nxt;
    logic [SIZE-1:0] addr;
    logic [SIZE-1:0] addr_nxt;
    logic            at_last_win;

    // One extra bit so a window base near the top of the address space cannot wrap.
    assign at_last_win = ({1'b0, addr} + STEP_W) >= LAYER_W;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            addr  <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        addr_nxt     = addr;
        in_ready     = 1'b0;
        load_enable  = 1'b0;
        load_address = '0;
        load_value   = '0;
        win_valid    = 1'b0;
        win_count    = '0;
        win_last     = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = LOAD;
                    addr_nxt  = '0;
                end
            end

            LOAD: begin
                busy         = 1'b1;
                in_ready     = 1'b1;
                load_address = addr;
                load_value   = in_data;
                load_enable  = in_valid;
                if (in_valid) begin
                    if (addr == LAST_ADDR) begin
                        state_nxt = SWEEP;
                        addr_nxt  = '0;
                    end else begin
                        addr_nxt = addr + ONE;
                    end
                end
            end

            SWEEP: begin
                // The bank reads combinationally, so window data is valid alongside win_valid.
                busy         = 1'b1;
                load_address = addr;
                win_valid    = 1'b1;
                win_count    = CW'(win_count_f(int'(addr), LAYER_SZ, OUTPUT_SZ));
                win_last     = at_last_win;
                if (win_ready) begin
                    if (at_last_win) begin
                        state_nxt = DONE;
                    end else begin
                        addr_nxt = addr + STEP;
                    end
                end
            end

            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
                addr_nxt  = '0;
            end

            default: begin
                state_nxt = IDLE;
                addr_nxt  = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Directed bench: three sequencer configurations (10/4, 10/5, 10/10), each driving its own bank model.
module tb_fc_layer_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        start_a;
    logic        start_bc;
    logic        in_valid;
    logic [15:0] in_data;
    logic        win_ready;

    logic        in_ready_a, le_a, win_valid_a, win_last_a, busy_a, done_a;
    logic [15:0] lv_a, la_a;
    logic [2:0]  win_count_a;
    logic        in_ready_b, le_b, win_valid_b, win_last_b, busy_b, done_b;
    logic [15:0] lv_b, la_b;
    logic [2:0]  win_count_b;
    logic        in_ready_c, le_c, win_valid_c, win_last_c, busy_c, done_c;
    logic [15:0] lv_c, la_c;
    logic [3:0]  win_count_c;

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    int d0;

    fc_layer_sequencer #(.SIZE(16), .LAYER_SZ(10), .OUTPUT_SZ(4)) u_a (
        .clk(clk), .rst(rst), .start(start_a), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .load_value(lv_a), .load_address(la_a), .load_enable(le_a),
        .win_valid(win_valid_a), .win_count(win_count_a), .win_last(win_last_a),
        .win_ready(win_ready), .busy(busy_a), .done(done_a)
    );

    fc_layer_sequencer #(.SIZE(16), .LAYER_SZ(10), .OUTPUT_SZ(5)) u_b (
        .clk(clk), .rst(rst), .start(start_bc), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .load_value(lv_b), .load_address(la_b), .load_enable(le_b),
        .win_valid(win_valid_b), .win_count(win_count_b), .win_last(win_last_b),
        .win_ready(win_ready), .busy(busy_b), .done(done_b)
    );

    fc_layer_sequencer #(.SIZE(16), .LAYER_SZ(10), .OUTPUT_SZ(10)) u_c (
        .clk(clk), .rst(rst), .start(start_bc), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_c), .load_value(lv_c), .load_address(la_c), .load_enable(le_c),
        .win_valid(win_valid_c), .win_count(win_count_c), .win_last(win_last_c),
        .win_ready(win_ready), .busy(busy_c), .done(done_c)
    );

    logic [15:0] bank_a [10];
    logic [15:0] bank_b [10];
    logic [15:0] bank_c [10];

    always @(posedge clk) begin
        if (le_a && la_a < 16'd10) bank_a[la_a[3:0]] <= lv_a;
        if (le_b && la_b < 16'd10) bank_b[la_b[3:0]] <= lv_b;
        if (le_c && la_c < 16'd10) bank_c[la_c[3:0]] <= lv_c;
        if (done_a) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_a(input string tag);
        chk({tag, "_in_ready"},  32'(in_ready_a),  0);
        chk({tag, "_load_en"},   32'(le_a),        0);
        chk({tag, "_load_addr"}, 32'(la_a),        0);
        chk({tag, "_load_val"},  32'(lv_a),        0);
        chk({tag, "_win_valid"}, 32'(win_valid_a), 0);
        chk({tag, "_win_count"}, 32'(win_count_a), 0);
        chk({tag, "_win_last"},  32'(win_last_a),  0);
        chk({tag, "_busy"},      32'(busy_a),      0);
        chk({tag, "_done"},      32'(done_a),      0);
    endtask

    // Checks one 10/4 window: base, count, last flag and bank contents against base_val.
    task automatic chk_win_a(input string tag, input int w, input int base_val);
        int cnt;
        cnt = (w < 2) ? 4 : 2;
        chk({tag, "_win_valid"}, 32'(win_valid_a), 1);
        chk({tag, "_win_addr"},  32'(la_a),        32'(4 * w));
        chk({tag, "_win_count"}, 32'(win_count_a), 32'(cnt));
        chk({tag, "_win_last"},  32'(win_last_a),  32'(w == 2));
        chk({tag, "_win_le"},    32'(le_a),        0);
        for (int j = 0; j < cnt; j++)
            chk({tag, "_win_data"}, 32'(bank_a[4 * w + j]), 32'(base_val + 4 * w + j));
    endtask

    // Full-rate fill of instance A with base_val..base_val+9.
    task automatic load_a(input string tag, input int base_val);
        for (int i = 0; i < 10; i++) begin
            in_data = 16'(base_val + i);
            @(negedge clk);
            chk({tag, "_load_en"},   32'(le_a),       1);
            chk({tag, "_load_addr"}, 32'(la_a),       32'(i));
            chk({tag, "_load_val"},  32'(lv_a),       32'(base_val + i));
            chk({tag, "_in_ready"},  32'(in_ready_a), 1);
            tick();
        end
        in_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start_a = 1'b0; start_bc = 1'b0;
        in_valid = 1'b0; in_data = '0; win_ready = 1'b0;
        tick();
        tick();
        @(negedge clk);
        chk_idle_a("reset");

        // Pass 1: full rate, always ready, 15 cycles from start through DONE.
        tick();
        rst = 1'b0; start_a = 1'b1; in_valid = 1'b1; in_data = 16'd100; win_ready = 1'b1;
        d0 = done_cnt;
        @(negedge clk);
        chk("p1_start_busy", 32'(busy_a), 0);
        chk("p1_start_in_ready", 32'(in_ready_a), 0);
        tick();
        start_a = 1'b0;
        load_a("p1", 100);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            chk_win_a("p1", w, 100);
            tick();
        end
        @(negedge clk);
        chk("p1_done", 32'(done_a), 1);
        chk("p1_done_busy", 32'(busy_a), 0);
        tick();
        @(negedge clk);
        chk("p1_done_after", 32'(done_a), 0);
        chk("p1_done_pulses", 32'(done_cnt - d0), 1);

        // Pass 2: in_valid toggles, window 1 stalled five cycles, start pulses ignored.
        tick();
        start_a = 1'b1; in_valid = 1'b0;
        tick();
        start_a = 1'b0;
        for (int c = 0; c < 19; c++) begin
            in_valid = (c % 2 == 0);
            in_data  = 16'(200 + c / 2);
            start_a  = (c == 3);
            @(negedge clk);
            chk("p2_load_en", 32'(le_a), 32'(in_valid));
            chk("p2_load_addr", 32'(la_a), 32'((c + 1) / 2));
            chk("p2_busy", 32'(busy_a), 1);
            tick();
        end
        in_valid = 1'b0; start_a = 1'b0;
        @(negedge clk);
        chk_win_a("p2w0", 0, 200);
        tick();
        win_ready = 1'b0; start_a = 1'b1;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            chk("p2_stall_addr", 32'(la_a), 4);
            chk("p2_stall_count", 32'(win_count_a), 4);
            chk("p2_stall_valid", 32'(win_valid_a), 1);
            tick();
        end
        win_ready = 1'b1; start_a = 1'b0;
        @(negedge clk);
        chk_win_a("p2w1", 1, 200);
        tick();
        @(negedge clk);
        chk_win_a("p2w2", 2, 200);
        tick();
        @(negedge clk);
        chk("p2_done", 32'(done_a), 1);
        tick();
        @(negedge clk);
        chk_idle_a("p2_end");

        // Pass 3: reset while window 1 is presented, then a fresh pass from addr 0.
        tick();
        start_a = 1'b1; in_valid = 1'b1; win_ready = 1'b1;
        d0 = done_cnt;
        tick();
        start_a = 1'b0;
        load_a("p3", 300);
        @(negedge clk);
        chk_win_a("p3w0", 0, 300);
        tick();
        win_ready = 1'b0;
        @(negedge clk);
        chk("p3_pre_rst_addr", 32'(la_a), 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk_idle_a("p3_rst");
        chk("p3_no_done", 32'(done_cnt - d0), 0);
        tick();
        start_a = 1'b1; in_valid = 1'b1; win_ready = 1'b1;
        tick();
        start_a = 1'b0;
        load_a("p4", 400);
        for (int w = 0; w < 3; w++) begin
            @(negedge clk);
            chk_win_a("p4", w, 400);
            tick();
        end
        @(negedge clk);
        chk("p4_done", 32'(done_a), 1);

        // Pass 5: OUTPUT_SZ=5 and OUTPUT_SZ=10 instances run side by side.
        tick();
        start_bc = 1'b1; in_valid = 1'b1; win_ready = 1'b1;
        tick();
        start_bc = 1'b0;
        for (int i = 0; i < 10; i++) begin
            in_data = 16'(500 + i);
            @(negedge clk);
            chk("p5_b_load_addr", 32'(la_b), 32'(i));
            chk("p5_c_load_addr", 32'(la_c), 32'(i));
            chk("p5_a_in_ready", 32'(in_ready_a), 0);
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("p5_b_w0_addr", 32'(la_b), 0);
        chk("p5_b_w0_count", 32'(win_count_b), 5);
        chk("p5_b_w0_last", 32'(win_last_b), 0);
        chk("p5_c_w0_valid", 32'(win_valid_c), 1);
        chk("p5_c_w0_addr", 32'(la_c), 0);
        chk("p5_c_w0_count", 32'(win_count_c), 10);
        chk("p5_c_w0_last", 32'(win_last_c), 1);
        for (int j = 0; j < 10; j++) begin
            chk("p5_c_data", 32'(bank_c[j]), 32'(500 + j));
            if (j < 5) chk("p5_b_w0_data", 32'(bank_b[j]), 32'(500 + j));
        end
        tick();
        @(negedge clk);
        chk("p5_b_w1_addr", 32'(la_b), 5);
        chk("p5_b_w1_count", 32'(win_count_b), 5);
        chk("p5_b_w1_last", 32'(win_last_b), 1);
        for (int j = 5; j < 10; j++) chk("p5_b_w1_data", 32'(bank_b[j]), 32'(500 + j));
        chk("p5_c_done", 32'(done_c), 1);
        tick();
        @(negedge clk);
        chk("p5_b_done", 32'(done_b), 1);
        chk("p5_c_done_after", 32'(done_c), 0);
        chk("p5_c_busy_after", 32'(busy_c), 0);
        tick();
        @(negedge clk);
        chk("p5_b_done_after", 32'(done_b), 0);
        chk("p5_b_win_valid_after", 32'(win_valid_b), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
